// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_req   : read request (master -> slave)
//   imem_addr  : read address (master -> slave)
//   imem_rdata : read data, valid only with imem_valid (slave -> master)
//   imem_valid : response strobe (slave -> master)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> ISSUE loop holding one instruction
// for decode, with stall hold and branch/jump redirect.
//   clk, rst_n            : clock, asynchronous active-low reset
//   pcSrc, pcTarget       : redirect select and target, sampled in ISSUE without stall
//   stall                 : keep the current instruction issued
//   imem (master)         : instruction-memory request/response bus
//   pc, pcPlus4           : held instruction address and pc+4 (combinational)
//   instr, instr_valid    : instruction register and issue flag
//   op, f3, f7            : instr[6:0], instr[14:12], instr[30] (combinational)
// Optional feature macro FETCH_MISALIGN_CHECK_EN adds output misaligned and a
// TRAP state entered on a redirect to a non-word-aligned target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pcSrc,
  input  logic [31:0]  pcTarget,
  input  logic         stall,
  fetch_unit_if.master imem,
  output logic [31:0]  pc,
  output logic [31:0]  pcPlus4,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [6:0]   op,
  output logic [2:0]   f3,
  output logic         f7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic         misaligned
`endif
);

  localparam int unsigned XLEN = 32;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, TRAP} state_e;
`else
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;
`endif

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              imem_req_q, imem_req_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              misaligned_q, misaligned_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q  <= misaligned_d;
`endif
    end
  end

  // Next state; imem_req is registered so it is high exactly while in FETCH
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_d  = misaligned_q;
`endif
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        imem_req_d = 1'b1;
        if (imem.imem_valid) begin
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
          imem_req_d    = 1'b0;
        end
      end
      ISSUE: begin
        if (!stall) begin
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pcSrc && (pcTarget[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
            state_d      = TRAP;
          end else begin
            pc_d       = pcSrc ? pcTarget : XLEN'(pc_q + XLEN'(4));
            state_d    = FETCH;
            imem_req_d = 1'b1;
          end
`else
          pc_d       = pcSrc ? pcTarget : XLEN'(pc_q + XLEN'(4));
          state_d    = FETCH;
          imem_req_d = 1'b1;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      TRAP: begin
        state_d = TRAP;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign pcPlus4        = XLEN'(pc_q + XLEN'(4));
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  // instr_q holds NOP_INSTR whenever nothing is issued, so fields follow it
  assign op             = instr_q[6:0];
  assign f3             = instr_q[14:12];
  assign f7             = instr_q[30];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned     = misaligned_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        stall;
  logic [31:0] pc, pcPlus4, instr;
  logic        instr_valid;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int errors = 0;
  int checks = 0;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcSrc       (pcSrc),
    .pcTarget    (pcTarget),
    .stall       (stall),
    .imem        (imem_bus),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op          (op),
    .f3          (f3),
    .f7          (f7)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, released 1 time unit after a rising edge
  task automatic apply_reset();
    pcSrc = 1'b0; pcTarget = 32'h0; stall = 1'b0;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = 32'h0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // From reset, bring the unit to ISSUE at address a (a loaded through a redirect)
  task automatic goto_issue(input logic [31:0] a, input logic [31:0] word);
    apply_reset();
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'h0000_0013;
    step(); step();                       // FETCH, ISSUE at RESET_PC
    pcSrc = 1'b1; pcTarget = a;
    step();                               // FETCH at a
    pcSrc = 1'b0; imem_bus.imem_rdata = word;
    step();                               // ISSUE at a
  endtask

  task automatic test_reset();
    apply_reset();
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    checks++; if (op !== 7'h13 || f3 !== 3'h0 || f7 !== 1'b0) begin errors++; $display("FAIL reset_fields got=%h/%h/%b exp=13/0/0", op, f3, f7); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_latency();
    apply_reset();
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'h0050_0093;
    step();
    checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL lat_edge1 got req=%b addr=%h v=%b exp req=1 addr=0 v=0", imem_bus.imem_req, imem_bus.imem_addr, instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || op !== 7'h13 || f3 !== 3'h0 || pc !== 32'h0 || instr !== 32'h0050_0093) begin
      errors++; $display("FAIL lat_edge2 got v=%b op=%h f3=%h pc=%h instr=%h exp v=1 op=13 f3=0 pc=0 instr=00500093", instr_valid, op, f3, pc, instr); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL lat_req_drop got=%b exp=0", imem_bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    int n = 0;
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8;
    apply_reset();
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'h0000_0033;
    for (int c = 0; c < 6; c++) begin
      step();
      if (imem_bus.imem_req === 1'b1 && n < 3) begin
        checks++; if (imem_bus.imem_addr !== exp_addr[n]) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", n, imem_bus.imem_addr, exp_addr[n]); end
        n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL seq_count got=%0d exp=3", n); end
  endtask

  task automatic test_branch();
    goto_issue(32'h10, 32'h0000_0063);
    checks++; if (pc !== 32'h10 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_setup got pc=%h v=%b exp pc=10 v=1", pc, instr_valid); end
    pcSrc = 1'b1; pcTarget = 32'h40; imem_bus.imem_valid = 1'b0;
    step();
    checks++; if (imem_bus.imem_addr !== 32'h40 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_target got addr=%h req=%b exp 40/1", imem_bus.imem_addr, imem_bus.imem_req); end
    pcTarget = 32'h80;
    step(); step();
    checks++; if (imem_bus.imem_addr !== 32'h40 || instr_valid !== 1'b0) begin errors++; $display("FAIL br_fetch_ignore got addr=%h v=%b exp 40/0", imem_bus.imem_addr, instr_valid); end
    pcSrc = 1'b0; imem_bus.imem_valid = 1'b1;
    step();
    checks++; if (pc !== 32'h40 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_issue got pc=%h v=%b exp 40/1", pc, instr_valid); end
  endtask

  task automatic test_stall();
    goto_issue(32'h30, 32'h1234_5037);
    imem_bus.imem_valid = 1'b0;
    stall = 1'b1; pcSrc = 1'b1; pcTarget = 32'h100;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (pc !== 32'h30 || instr !== 32'h1234_5037 || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got pc=%h instr=%h v=%b req=%b exp 30/12345037/1/0", c, pc, instr, instr_valid, imem_bus.imem_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h100 || imem_bus.imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== NOP) begin
      errors++; $display("FAIL stall_release got pc=%h req=%b v=%b instr=%h exp 100/1/0/%h", pc, imem_bus.imem_req, instr_valid, instr, NOP); end
    pcSrc = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    goto_issue(32'h1C, 32'h0000_0013);
    imem_bus.imem_valid = 1'b0;
    step();                               // FETCH at 0x20
    checks++; if (pc !== 32'h20 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rmf_setup got pc=%h req=%b exp 20/1", pc, imem_bus.imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmf_async got pc=%h req=%b exp 0/0", pc, imem_bus.imem_req); end
    step();
    rst_n = 1'b1;
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    step();                               // IDLE edge: late response ignored
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || imem_bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rmf_late got v=%b instr=%h req=%b exp 0/%h/1", instr_valid, instr, imem_bus.imem_req, NOP); end
  endtask

  task automatic test_wrap();
    goto_issue(32'hFFFF_FFFC, 32'h0000_0013);
    checks++; if (pcPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=0", pcPlus4); end
    step();
    checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", imem_bus.imem_addr); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    goto_issue(32'h50, 32'h0000_0013);
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_initial got=%b exp=0", misaligned); end
    pcSrc = 1'b1; pcTarget = 32'h42;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (misaligned !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== 32'h50 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL mis_trap%0d got m=%b req=%b pc=%h v=%b exp 1/0/50/0", c, misaligned, imem_bus.imem_req, pc, instr_valid); end
    end
    pcSrc = 1'b0;
    apply_reset();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_reset got=%b exp=0", misaligned); end
  endtask
`endif

  // Random inputs against a transaction-level model: the unit either waits
  // for a word at m_pc or holds one issued word until released.
  task automatic test_random();
    logic [31:0] m_pc, m_instr;
    logic        m_hold, m_started;
    logic        v, st, ps;
    logic [31:0] rd, tg;
    apply_reset();
    m_pc = 32'h0; m_instr = NOP; m_hold = 1'b0; m_started = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v  = 1'($urandom_range(0, 2) != 0);
      st = 1'($urandom_range(0, 2) == 0);
      ps = 1'($urandom_range(0, 3) == 0);
      rd = $urandom;
      tg = $urandom & 32'hFFFF_FFFC;
      imem_bus.imem_valid = v; imem_bus.imem_rdata = rd;
      stall = st; pcSrc = ps; pcTarget = tg;
      if (!m_started) m_started = 1'b1;
      else if (!m_hold) begin
        if (v) begin m_hold = 1'b1; m_instr = rd; end
      end else if (!st) begin
        m_pc = ps ? tg : m_pc + 32'd4;
        m_hold = 1'b0; m_instr = NOP;
      end
      step();
      checks++;
      if (pc !== m_pc || pcPlus4 !== m_pc + 32'd4 || instr !== m_instr || instr_valid !== m_hold ||
          imem_bus.imem_req !== (m_started && !m_hold) || imem_bus.imem_addr !== m_pc ||
          op !== m_instr[6:0] || f3 !== m_instr[14:12] || f7 !== m_instr[30]) begin
        errors++;
        $display("FAIL rand%0d got pc=%h instr=%h v=%b req=%b exp pc=%h instr=%h v=%b req=%b", c, pc, instr,
                 instr_valid, imem_bus.imem_req, m_pc, m_instr, m_hold, m_started && !m_hold);
      end
    end
    stall = 1'b0; pcSrc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_fetch_latency();
    test_sequential();
    test_branch();
    test_stall();
    test_reset_mid_fetch();
    test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
